// File: rtl/uart_rx_if.sv
// Receive-side signal bundle between the baud generator/serial line and the
// UART receiver; the receiver uses the slave view.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_tick;
  logic                 i_rxd;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
  logic                 o_busy;

  modport master (
    output i_tick, i_rxd,
    input  o_data, o_valid, o_frame_err, o_busy
  );

  modport slave (
    input  i_tick, i_rxd,
    output o_data, o_valid, o_frame_err, o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples a synchronized serial line, samples each bit
// at its centre and presents good bytes / framing errors as one-clk strobes.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               state_q;
  logic                 sync1_q;
  logic                 sync2_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 rxd_s;

  assign rxd_s = sync2_q;

  // Sync flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= bus.i_rxd;
      sync2_q     <= sync1_q;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          tick_cnt_q <= '0;
          if (!rxd_s) begin
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (bus.i_tick) begin
            if (tick_cnt_q == TICK_HALF) begin
              tick_cnt_q <= '0;
              if (!rxd_s) begin
                bit_cnt_q <= '0;
                state_q   <= ST_DATA;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (bus.i_tick) begin
            if (tick_cnt_q == TICK_LAST) begin
              shift_q    <= {rxd_s, shift_q[DATA_BITS-1:1]};
              tick_cnt_q <= '0;
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BIT_LAST) begin
                state_q <= ST_STOP;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        // Deciding at stop-bit centre leaves half a bit to catch a
        // back-to-back start edge.
        ST_STOP: begin
          if (bus.i_tick) begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              if (rxd_s) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= ST_BREAK;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        ST_BREAK: begin
          if (rxd_s) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are generated from the 8N1 line format
// and each strobe is matched against a queue of expected frame outcomes.
module tb_uart_rx;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) u_if ();

  uart_rx #(
    .OVERSAMPLE(OS),
    .DATA_BITS (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  typedef struct packed {
    logic       isErr;
    logic [7:0] data;
  } frameEvent_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          tickDiv = 4;
  int          tickPhase = 0;
  int          bitHundredths = 6400;
  int          fracAcc = 0;
  frameEvent_t expQ[$];
  frameEvent_t evCur;
  logic [7:0]  lastGood = 8'h00;
  logic        prevStrobe = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Baud generator model: one-clk tick every tickDiv clocks.
  initial begin
    u_if.i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tickPhase++;
      if (tickPhase >= tickDiv) begin
        tickPhase   = 0;
        u_if.i_tick = 1'b1;
      end else begin
        u_if.i_tick = 1'b0;
      end
    end
  end

  task automatic setBaud(input int div, input int hundredthsPerBit);
    tickDiv       = div;
    bitHundredths = hundredthsPerBit;
    fracAcc       = 0;
  endtask

  // Holds the line for one bit period; fractional clocks carry into the next bit.
  task automatic driveBit(input logic v);
    int total;
    u_if.i_rxd = v;
    total      = fracAcc + bitHundredths;
    fracAcc    = total % 100;
    repeat (total / 100) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleBits(input int n);
    for (int i = 0; i < n; i++) driveBit(1'b1);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    frameEvent_t ev;
    ev.isErr = ~stopBit;
    ev.data  = data;
    expQ.push_back(ev);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    driveBit(stopBit);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_data"},  32'(u_if.o_data), 32'h0);
    checkOutput({tag, "_valid"}, 32'(u_if.o_valid), 32'h0);
    checkOutput({tag, "_ferr"},  32'(u_if.o_frame_err), 32'h0);
    checkOutput({tag, "_busy"},  32'(u_if.o_busy), 32'h0);
  endtask

  // Every strobe consumes one expected frame outcome.
  always @(negedge clk) begin
    if (!reset) begin
      lastGood   <= 8'h00;
      prevStrobe <= 1'b0;
    end else begin
      prevStrobe <= u_if.o_valid | u_if.o_frame_err;
      if (u_if.o_valid || u_if.o_frame_err) begin
        checkOutput("strobeExpected", 32'(u_if.o_valid | u_if.o_frame_err), 32'(expQ.size() != 0));
        checkOutput("strobeOverlap", 32'(u_if.o_valid & u_if.o_frame_err), 32'h0);
        checkOutput("strobeWidth", 32'(prevStrobe), 32'h0);
        if (expQ.size() != 0) begin
          evCur = expQ.pop_front();
          checkOutput("strobeKind", 32'(u_if.o_frame_err), 32'(evCur.isErr));
          if (evCur.isErr) begin
            checkOutput("errDataHold", 32'(u_if.o_data), 32'(lastGood));
          end else begin
            checkOutput("rxData", 32'(u_if.o_data), 32'(evCur.data));
            lastGood <= evCur.data;
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] partial;
    u_if.i_rxd = 1'b1;
    setBaud(4, 64 * 100);
    repeat (10) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    reset = 1'b1;
    idleBits(1);
    checkOutput("idleBusy", 32'(u_if.o_busy), 32'h0);

    applyStimulus(8'hA5, 1'b1);
    idleBits(1);
    checkOutput("basicBusyLow", 32'(u_if.o_busy), 32'h0);
    checkOutput("basicDrained", 32'(expQ.size()), 32'h0);

    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    idleBits(1);
    checkOutput("b2bDrained", 32'(expQ.size()), 32'h0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'b1);
      idleBits($urandom_range(0, 2));
    end
    idleBits(1);

    u_if.i_rxd = 1'b0;
    repeat (5 * tickDiv) @(posedge clk);
    #1;
    u_if.i_rxd = 1'b1;
    idleBits(1);
    checkOutput("glitchBusy", 32'(u_if.o_busy), 32'h0);
    checkOutput("glitchDataHold", 32'(u_if.o_data), 32'(lastGood));

    applyStimulus(8'h3C, 1'b0);
    driveBit(1'b0);
    checkOutput("breakBusy", 32'(u_if.o_busy), 32'h1);
    driveBit(1'b0);
    driveBit(1'b0);
    checkOutput("breakStillBusy", 32'(u_if.o_busy), 32'h1);
    idleBits(1);
    applyStimulus(8'h81, 1'b1);
    idleBits(1);
    checkOutput("ferrDrained", 32'(expQ.size()), 32'h0);

    partial = 8'h5A;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(partial[i]);
    u_if.i_rxd = partial[4];
    repeat (32) @(posedge clk);
    #1;
    reset      = 1'b0;
    u_if.i_rxd = 1'b1;
    #2;
    checkResetOutputs("midReset");
    repeat (5) @(posedge clk);
    #1;
    reset   = 1'b1;
    fracAcc = 0;
    idleBits(1);
    applyStimulus(8'h12, 1'b1);
    idleBits(1);
    checkOutput("postResetDrained", 32'(expQ.size()), 32'h0);

    // Transmitter 3% fast with a tick on every clock.
    setBaud(1, 1553);
    idleBits(2);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 3) == 0) idleBits(1);
    end
    idleBits(2);
    checkOutput("jitterDrained", 32'(expQ.size()), 32'h0);
    checkOutput("finalBusy", 32'(u_if.o_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver that sits directly downstream of the UART transmitter; it consumes the transmitter's 8N1 serial line (idle-high, start bit 0, 8 data bits LSB-first, stop bit 1). It oversamples the line using an enable tick from the baud generator, locates each bit centre, and deserializes the byte. Each good frame is presented as a parallel byte with a one-cycle valid strobe; a bad stop bit is reported with a one-cycle framing-error strobe.

Parameters:
OVERSAMPLE, 16, i_tick pulses per bit period; must be even and >= 4
DATA_BITS, 8, data bits per frame; o_data width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
i_tick  input  1  oversample enable from baud generator; one clk wide, OVERSAMPLE per bit
i_rxd  input  1  asynchronous serial input, idle high
o_data  output  DATA_BITS  last correctly received byte
o_valid  output  1  one-clk strobe: o_data updated with a good frame
o_frame_err  output  1  one-clk strobe: stop bit sampled low
o_busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: reset is reset, asynchronous, active-low; clock is clk. All flops reset asynchronously on reset low and are clocked on posedge clk.
- Reset values:
  - o_data = 0, o_valid = 0, o_frame_err = 0, o_busy = 0.
  - state = IDLE; tick_cnt = 0, bit_cnt = 0, shift register = 0.
  - Both synchronizer flops = 1.
- Input sync: i_rxd passes through 2 flops to give rxd_s; all decisions use rxd_s only. Line-to-rxd_s latency is 2 clk.
- Counters:
  - tick_cnt is clog2(OVERSAMPLE) bits; bit_cnt is clog2(DATA_BITS+1) bits.
  - Both advance only in cycles where i_tick=1; the FSM holds otherwise, except IDLE and BREAK exits.
- States and transitions:
  - IDLE: tick_cnt=0. On rxd_s==0 (any cycle, tick not required), go to START.
  - START: on each tick, tick_cnt++. On the tick where tick_cnt==OVERSAMPLE/2-1 (start-bit centre):
    - rxd_s==0: tick_cnt=0, bit_cnt=0, go to DATA.
    - rxd_s==1: glitch; go to IDLE with no strobe.
  - DATA: on each tick, tick_cnt++. On the tick where tick_cnt==OVERSAMPLE-1: shift right with rxd_s into the MSB, tick_cnt=0, bit_cnt++. When bit_cnt reaches DATA_BITS-1 on this sample, go to STOP.
  - STOP: on the tick where tick_cnt==OVERSAMPLE-1:
    - rxd_s==1: o_data<=shift, o_valid=1 for the next clk, go to IDLE.
    - rxd_s==0: o_frame_err=1 for the next clk, o_data unchanged, go to BREAK.
  - BREAK: wait for rxd_s==1, then go to IDLE. This prevents a held-low line from re-triggering frames.
- Timing:
  - The stop-bit decision is made at stop-bit centre, so the receiver is back in IDLE half a bit early and can accept a back-to-back start bit with no gap.
  - o_valid and o_frame_err are registered: high exactly 1 clk, in the cycle after the deciding tick edge. They are never high together.
- o_data holds its value between frames.
- Reset asserted mid-frame: immediate return to reset values; no strobe is issued for the partial frame.
- i_tick held high continuously is legal: 1 tick per clk.

Test Plan:
- Basic frame: i_tick every 4 clk, OVERSAMPLE=16; send 0xA5 at 64 clk/bit -> exactly one o_valid pulse, o_data=0xA5, o_frame_err stays 0, o_busy low after the pulse.
- Back-to-back: send 0x00 then 0xFF with no idle gap -> two o_valid pulses, with o_data=0x00 then o_data=0xFF.
- Glitch reject: drive i_rxd low for 5 ticks (shorter than a half bit), then high -> no o_valid, no o_frame_err, o_busy returns 0, o_data unchanged.
- Framing error: send 0x3C with stop bit 0, keep the line low for 3 bit times, then send 0x81 -> one o_frame_err pulse, o_data keeps its prior value, no start is detected while low, then o_valid with o_data=0x81.
- Reset mid-frame: assert reset during data bit 4 of 0x5A, release, then send 0x12 -> all outputs 0 during reset, no strobe for 0x5A, then o_valid with o_data=0x12.
- Jitter/edge timing: tick every clk, baud offset +3%, random bytes x100 -> every byte is received correctly and no framing errors occur.
